// File: rtl/seg_scan_driver_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan driver.
package seg_scan_driver_pkg;

  // Scan phase: dark while idle, dark during the blanking part of a slot,
  // lit during the show part of a slot.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } scan_state_t;

  // Active-low segment patterns.
  localparam logic [6:0] SEG_BLANK  = 7'h7F;
  localparam logic [6:0] SEG_ALL_ON = 7'h00;

  localparam int unsigned DEFAULT_NUM_DIGITS = 5;

  // Ceiling log2, never less than 1 so that it can size a vector directly.
  function automatic int unsigned clog2_min1(input int unsigned value);
    int unsigned width = 1;
    while ((64'd1 << width) < 64'(value)) width++;
    return width;
  endfunction

endpackage

// File: rtl/seg_scan_driver_slot_timer.sv
// Slot timer: owns the in-slot cycle counter and the BLANK/SHOW phase.
// slot_done marks the last cycle of a slot; show_phase reports whether the
// phase being entered on the coming edge is SHOW, so the parent can register
// outputs that line up with the phase actually held.
module seg_slot_timer
  import seg_scan_driver_pkg::*;
#(
  parameter int unsigned PRESCALE     = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic idle,
  output logic slot_done,
  output logic show_phase
);

  localparam int unsigned CW = clog2_min1(PRESCALE);
  localparam logic [CW-1:0] BLANK_LAST =
    CW'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SHOW_LAST = CW'(PRESCALE - BLANK_CYCLES - 1);
  // With no blanking every slot opens directly in SHOW.
  localparam scan_state_t SLOT_ENTRY = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;

  scan_state_t    phase, phase_next;
  logic [CW-1:0]  cnt, cnt_next;

  assign idle       = (phase == ST_IDLE);
  assign show_phase = (phase_next == ST_SHOW);

  // Next phase and counter; dropping the enable forces idle from any phase.
  always_comb begin
    phase_next = phase;
    cnt_next   = cnt;
    slot_done  = 1'b0;
    if (!en) begin
      phase_next = ST_IDLE;
      cnt_next   = '0;
    end else begin
      unique case (phase)
        ST_IDLE: begin
          phase_next = SLOT_ENTRY;
          cnt_next   = '0;
        end
        ST_BLANK: begin
          if (cnt == BLANK_LAST) begin
            phase_next = ST_SHOW;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + CW'(1);
          end
        end
        ST_SHOW: begin
          if (cnt == SHOW_LAST) begin
            slot_done  = 1'b1;
            phase_next = SLOT_ENTRY;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + CW'(1);
          end
        end
        default: begin
          phase_next = ST_IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Phase and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase <= ST_IDLE;
      cnt   <= '0;
    end else begin
      phase <= phase_next;
      cnt   <= cnt_next;
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 7-segment driver: snapshots up to five active-low digit
// patterns once per frame and scans them onto one shared segment bus with
// active-low digit enables, blanking dead-time between digits, lamp test and
// a frame-start strobe.
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = DEFAULT_NUM_DIGITS,
  parameter int unsigned PRESCALE     = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_n,
  input  logic                  i_En,
  input  logic                  i_Lamp_test,
  input  logic [6:0]            i_Seg_first,
  input  logic [6:0]            i_Seg_second,
  input  logic [6:0]            i_Seg_third,
  input  logic [6:0]            i_Seg_fourth,
  input  logic [6:0]            i_Seg_fifth,
  output logic [6:0]            o_Seg,
  output logic [NUM_DIGITS-1:0] o_Dig,
  output logic                  o_Frame_start
);

  localparam int unsigned IW = clog2_min1(NUM_DIGITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

  logic            idle, slot_done, show_phase;
  logic            frame_start;
  logic [IW-1:0]   idx, idx_next;
  logic [6:0]      seg_in    [5];
  logic [6:0]      fresh     [NUM_DIGITS];
  logic [6:0]      snap      [NUM_DIGITS];
  logic [6:0]      snap_next [NUM_DIGITS];
  logic [6:0]            seg_next;
  logic [NUM_DIGITS-1:0] dig_next;

  seg_slot_timer #(
    .PRESCALE     (PRESCALE),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_slot_timer (
    .clk        (i_Clk),
    .rst_n      (i_Rst_n),
    .en         (i_En),
    .idle       (idle),
    .slot_done  (slot_done),
    .show_phase (show_phase)
  );

  assign seg_in[0] = i_Seg_first;
  assign seg_in[1] = i_Seg_second;
  assign seg_in[2] = i_Seg_third;
  assign seg_in[3] = i_Seg_fourth;
  assign seg_in[4] = i_Seg_fifth;

  // Digits beyond the five pattern inputs are permanently dark.
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_fresh
    if (k < 5) begin : g_in
      assign fresh[k] = seg_in[k];
    end else begin : g_dark
      assign fresh[k] = SEG_BLANK;
    end
  end

  // Frame sequencing, snapshot capture and output decode. Outputs are
  // registered from next-state values so that in every cycle they reflect
  // the phase, digit index and snapshot actually held in that cycle.
  always_comb begin
    frame_start = i_En && (idle || (slot_done && idx == LAST_IDX));

    idx_next = idx;
    if (!i_En || idle) begin
      idx_next = '0;
    end else if (slot_done) begin
      idx_next = (idx == LAST_IDX) ? '0 : idx + IW'(1);
    end

    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      snap_next[k] = frame_start ? fresh[k] : snap[k];
    end

    dig_next = '1;
    seg_next = SEG_BLANK;
    if (show_phase) begin
      dig_next[idx_next] = 1'b0;
      seg_next = i_Lamp_test ? SEG_ALL_ON : snap_next[idx_next];
    end
  end

  // Index, snapshot and output registers with synchronous active-low reset.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      idx <= '0;
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
        snap[k] <= SEG_BLANK;
      end
      o_Seg         <= SEG_BLANK;
      o_Dig         <= '1;
      o_Frame_start <= 1'b0;
    end else begin
      idx           <= idx_next;
      snap          <= snap_next;
      o_Seg         <= seg_next;
      o_Dig         <= dig_next;
      o_Frame_start <= frame_start;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: PRESCALE=8, NUM_DIGITS=5, one build
// with BLANK_CYCLES=2 (dut_a) and one with BLANK_CYCLES=0 (dut_b).
module tb_seg_scan_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, rst_n_b, en, en_b, lamp;
  logic [6:0] s1, s2, s3, s4, s5;
  logic [6:0] seg_a, seg_b;
  logic [4:0] dig_a, dig_b;
  logic       fs_a, fs_b;

  seg_scan_driver #(
    .NUM_DIGITS   (5),
    .PRESCALE     (8),
    .BLANK_CYCLES (2)
  ) dut_a (
    .i_Clk         (clk),
    .i_Rst_n       (rst_n),
    .i_En          (en),
    .i_Lamp_test   (lamp),
    .i_Seg_first   (s1),
    .i_Seg_second  (s2),
    .i_Seg_third   (s3),
    .i_Seg_fourth  (s4),
    .i_Seg_fifth   (s5),
    .o_Seg         (seg_a),
    .o_Dig         (dig_a),
    .o_Frame_start (fs_a)
  );

  seg_scan_driver #(
    .NUM_DIGITS   (5),
    .PRESCALE     (8),
    .BLANK_CYCLES (0)
  ) dut_b (
    .i_Clk         (clk),
    .i_Rst_n       (rst_n_b),
    .i_En          (en_b),
    .i_Lamp_test   (lamp),
    .i_Seg_first   (s1),
    .i_Seg_second  (s2),
    .i_Seg_third   (s3),
    .i_Seg_fourth  (s4),
    .i_Seg_fifth   (s5),
    .o_Seg         (seg_b),
    .o_Dig         (dig_b),
    .o_Frame_start (fs_b)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int         cyc;
    logic       fs;
    logic [4:0] dig;
    logic [6:0] seg;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int c, input logic f, input logic [4:0] d, input logic [6:0] s);
    vec_t v;
    v.cyc = c; v.fs = f; v.dig = d; v.seg = s;
    tbl.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic check_a(input logic f, input logic [4:0] d, input logic [6:0] s);
    check("A.frame_start", {7'd0, fs_a}, {7'd0, f});
    check("A.dig", {3'd0, dig_a}, {3'd0, d});
    check("A.seg", {1'b0, seg_a}, {1'b0, s});
  endtask

  task automatic check_b(input logic f, input logic [4:0] d, input logic [6:0] s);
    check("B.frame_start", {7'd0, fs_b}, {7'd0, f});
    check("B.dig", {3'd0, dig_b}, {3'd0, d});
    check("B.seg", {1'b0, seg_b}, {1'b0, s});
  endtask

  initial begin
    int         ti;
    logic [6:0] pat [5];
    logic [4:0] one_hot;
    int         slot;

    rst_n = 1'b0; rst_n_b = 1'b0; en = 1'b1; en_b = 1'b1; lamp = 1'b0;
    s1 = 7'h40; s2 = 7'h79; s3 = 7'h24; s4 = 7'h30; s5 = 7'h19;

    // Expected dut_a outputs at selected cycles after reset release
    // (cycle 0 = first cycle after the first edge with reset released).
    add(0,  1'b1, 5'h1F, 7'h7F);
    add(1,  1'b0, 5'h1F, 7'h7F);
    add(2,  1'b0, 5'h1E, 7'h40);
    add(7,  1'b0, 5'h1E, 7'h40);
    add(8,  1'b0, 5'h1F, 7'h7F);
    add(9,  1'b0, 5'h1F, 7'h7F);
    add(10, 1'b0, 5'h1D, 7'h79);
    add(15, 1'b0, 5'h1D, 7'h79);
    add(18, 1'b0, 5'h1B, 7'h24);
    add(23, 1'b0, 5'h1B, 7'h24);
    add(26, 1'b0, 5'h17, 7'h30);
    add(34, 1'b0, 5'h0F, 7'h19);
    add(39, 1'b0, 5'h0F, 7'h19);
    add(40, 1'b1, 5'h1F, 7'h7F);
    add(41, 1'b0, 5'h1F, 7'h7F);
    add(42, 1'b0, 5'h1E, 7'h12);
    add(47, 1'b0, 5'h1E, 7'h12);
    add(67, 1'b0, 5'h17, 7'h30);
    add(68, 1'b0, 5'h17, 7'h00);
    add(71, 1'b0, 5'h17, 7'h00);
    add(72, 1'b0, 5'h1F, 7'h7F);
    add(73, 1'b0, 5'h1F, 7'h7F);
    add(74, 1'b0, 5'h0F, 7'h00);
    add(75, 1'b0, 5'h0F, 7'h19);
    add(80, 1'b1, 5'h1F, 7'h7F);
    add(82, 1'b0, 5'h1E, 7'h12);
    add(99, 1'b0, 5'h1B, 7'h24);
    add(100, 1'b0, 5'h1B, 7'h24);

    // Reset held with enable high: outputs stay at reset values.
    for (int i = 0; i < 3; i++) begin
      tick();
      cyc = i - 3;
      check_a(1'b0, 5'h1F, 7'h7F);
    end
    rst_n = 1'b1;

    // Two full frames plus part of a third; mid-frame input change,
    // lamp test over digit 3 and its following blanking.
    ti = 0;
    for (int c = 0; c <= 100; c++) begin
      tick();
      cyc = c;
      if (ti < tbl.size() && tbl[ti].cyc == c) begin
        check_a(tbl[ti].fs, tbl[ti].dig, tbl[ti].seg);
        ti++;
      end else begin
        check("A.frame_start", {7'd0, fs_a}, {7'd0, (c % 40 == 0)});
      end
      if (c == 20)  s1 = 7'h12;
      if (c == 67)  lamp = 1'b1;
      if (c == 74)  lamp = 1'b0;
      if (c == 100) en = 1'b0;
    end

    // Enable dropped mid-SHOW of digit 2: dark from the next cycle.
    s1 = 7'h02;
    for (int i = 0; i < 3; i++) begin
      tick();
      cyc++;
      check_a(1'b0, 5'h1F, 7'h7F);
    end

    // Re-enable: restart at digit 0 with a fresh snapshot.
    en = 1'b1;
    tick(); cyc++; check_a(1'b1, 5'h1F, 7'h7F);
    tick(); cyc++; check_a(1'b0, 5'h1F, 7'h7F);
    tick(); cyc++; check_a(1'b0, 5'h1E, 7'h02);
    repeat (5) begin tick(); cyc++; end
    check_a(1'b0, 5'h1E, 7'h02);
    tick(); cyc++; check_a(1'b0, 5'h1F, 7'h7F);
    tick(); tick(); cyc += 2; check_a(1'b0, 5'h1D, 7'h79);

    // dut_b has been held in reset with its enable high the whole time.
    check_b(1'b0, 5'h1F, 7'h7F);

    // No-blanking build: every cycle lit, 8 cycles per digit.
    s1 = 7'h40;
    pat[0] = 7'h40; pat[1] = 7'h79; pat[2] = 7'h24; pat[3] = 7'h30; pat[4] = 7'h19;
    rst_n_b = 1'b1;
    for (int c = 0; c <= 43; c++) begin
      tick();
      cyc = c;
      slot = (c / 8) % 5;
      one_hot = 5'h01 << slot;
      check_b((c % 40 == 0), 5'h1F ^ one_hot, pat[slot]);
    end

    // Synchronous reset mid-slot, enable still high: reset wins.
    rst_n_b = 1'b0;
    tick(); cyc++; check_b(1'b0, 5'h1F, 7'h7F);
    tick(); cyc++; check_b(1'b0, 5'h1F, 7'h7F);
    rst_n_b = 1'b1;
    tick(); cyc++; check_b(1'b1, 5'h1E, 7'h40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
